// File: rtl/inst_mem_loader.sv
// inst_mem_loader: word-addressed instruction RAM with a zero-latency fetch
// port for the CPU and a byte-stream loader (valid/ready) that fills it at
// boot or on request. cpu_run holds the CPU in reset until the image is in.
module inst_mem_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk_cpu,
    input  logic              reset,
    input  logic [31:0]       pc,
    output logic [WORD_W-1:0] inst,
    input  logic [7:0]        ld_data,
    input  logic              ld_valid,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              reload,
    output logic              cpu_run,
    output logic [ADDR_W:0]   words_loaded,
    output logic              err_overflow
);

    localparam int unsigned    DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   WL_ONE   = 1;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_PAD,
        ST_RUN
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [1:0]          byte_cnt;
    logic [ADDR_W-1:0]   wr_addr;
    logic [WORD_W-9:0]   shift;
    logic [WORD_W-1:0]   word_data;
    logic [WORD_W-1:0]   mem [DEPTH];

    logic xfer;
    logic word_done;
    logic ram_full;
    logic do_write;
    logic discard;
    logic pc_lsb_unused;

    // pc[1:0] selects a byte within the word and has no meaning here
    assign pc_lsb_unused = ^pc[1:0];

    assign xfer      = ld_valid && ld_ready;
    assign word_done = (xfer && (byte_cnt == 2'd3)) || (state == ST_PAD);
    // words_loaded reaching DEPTH means every slot has been written once
    assign ram_full  = words_loaded[ADDR_W];
    assign do_write  = word_done && !ram_full;
    assign discard   = word_done && ram_full;

    // State register
    always_ff @(posedge clk_cpu or negedge reset) begin
        if (!reset) begin
            state <= ST_LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and loader handshake
    always_comb begin
        state_next = state;
        ld_ready   = 1'b0;
        case (state)
            ST_LOAD: begin
                ld_ready = 1'b1;
                if (xfer && ld_last) begin
                    state_next = (byte_cnt == 2'd3) ? ST_RUN : ST_PAD;
                end
            end
            ST_PAD: begin
                state_next = ST_RUN;
            end
            ST_RUN: begin
                if (reload) begin
                    state_next = ST_LOAD;
                end
            end
            default: begin
                state_next = ST_LOAD;
            end
        endcase
    end

    // Word to be written: a full big-endian word, or a partial word
    // left-justified with zero fill when the image ends mid-word
    always_comb begin
        word_data = '0;
        if (state == ST_PAD) begin
            case (byte_cnt)
                2'd1:    word_data = {shift[7:0],  24'h00_0000};
                2'd2:    word_data = {shift[15:0], 16'h0000};
                default: word_data = {shift[23:0], 8'h00};
            endcase
        end else begin
            word_data = {shift, ld_data};
        end
    end

    // Byte assembly, write pointer, load bookkeeping and run flag
    always_ff @(posedge clk_cpu or negedge reset) begin
        if (!reset) begin
            byte_cnt     <= '0;
            wr_addr      <= '0;
            shift        <= '0;
            words_loaded <= '0;
            err_overflow <= 1'b0;
            cpu_run      <= 1'b0;
        end else begin
            cpu_run <= (state_next == ST_RUN);
            if (state == ST_RUN) begin
                if (reload) begin
                    byte_cnt     <= '0;
                    wr_addr      <= '0;
                    shift        <= '0;
                    words_loaded <= '0;
                    err_overflow <= 1'b0;
                end
            end else begin
                if (xfer) begin
                    shift    <= {shift[15:0], ld_data};
                    byte_cnt <= byte_cnt + 2'd1;
                end
                if (state == ST_PAD) begin
                    byte_cnt <= '0;
                end
                if (do_write) begin
                    wr_addr      <= wr_addr + ADDR_ONE;
                    words_loaded <= words_loaded + WL_ONE;
                end
                if (discard) begin
                    err_overflow <= 1'b1;
                end
            end
        end
    end

    // Instruction RAM write port; contents survive reset
    always_ff @(posedge clk_cpu) begin
        if (do_write) begin
            mem[wr_addr] <= word_data;
        end
    end

    // Fetch port: NOP while loading or when pc is beyond the RAM
    always_comb begin
        inst = '0;
        if (cpu_run && (pc[31:ADDR_W+2] == '0)) begin
            inst = mem[pc[ADDR_W+1:2]];
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: two loaders (256-word and 4-word RAM) fed the same
// byte stream, compared against an image-level reference model.
module tb_inst_mem_loader;

    logic        clk_cpu  = 1'b0;
    logic        reset    = 1'b1;
    logic [31:0] pc       = '0;
    logic [7:0]  ld_data  = '0;
    logic        ld_valid = 1'b0;
    logic        ld_last  = 1'b0;
    logic        reload   = 1'b0;

    logic [31:0] inst_a, inst_b;
    logic        ready_a, ready_b, run_a, run_b, err_a, err_b;
    logic [8:0]  wl_a;
    logic [2:0]  wl_b;

    // 100 MHz CPU clock
    always #5 clk_cpu = ~clk_cpu;

    inst_mem_loader #(.ADDR_W(8), .WORD_W(32)) dut_a (
        .clk_cpu(clk_cpu), .reset(reset), .pc(pc), .inst(inst_a),
        .ld_data(ld_data), .ld_valid(ld_valid), .ld_last(ld_last),
        .ld_ready(ready_a), .reload(reload), .cpu_run(run_a),
        .words_loaded(wl_a), .err_overflow(err_a)
    );

    inst_mem_loader #(.ADDR_W(2), .WORD_W(32)) dut_b (
        .clk_cpu(clk_cpu), .reset(reset), .pc(pc), .inst(inst_b),
        .ld_data(ld_data), .ld_valid(ld_valid), .ld_last(ld_last),
        .ld_ready(ready_b), .reload(reload), .cpu_run(run_b),
        .words_loaded(wl_b), .err_overflow(err_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] get_inst(input int k);
        return (k == 0) ? inst_a : inst_b;
    endfunction
    function automatic logic get_run(input int k);
        return (k == 0) ? run_a : run_b;
    endfunction
    function automatic logic get_ready(input int k);
        return (k == 0) ? ready_a : ready_b;
    endfunction
    function automatic logic get_err(input int k);
        return (k == 0) ? err_a : err_b;
    endfunction
    function automatic logic [31:0] get_wl(input int k);
        return (k == 0) ? 32'(wl_a) : 32'(wl_b);
    endfunction

    // Reference model: image-level view of the RAM contents
    int unsigned depth [2] = '{256, 4};
    int unsigned aw    [2] = '{8, 2};
    logic [31:0] m_mem [2][256];
    bit          m_val [2][256];
    int unsigned m_bytes;
    int unsigned m_words;
    logic [31:0] m_cur;
    bit          m_run;
    logic [7:0]  img [$];

    task automatic m_restart();
        m_bytes = 0;
        m_words = 0;
        m_cur   = '0;
        m_run   = 1'b0;
    endtask

    task automatic m_commit(input logic [31:0] w);
        for (int k = 0; k < 2; k++) begin
            if (m_words < depth[k]) begin
                m_mem[k][m_words] = w;
                m_val[k][m_words] = 1'b1;
            end
        end
        m_words++;
    endtask

    task automatic m_push(input logic [7:0] b);
        m_cur = {m_cur[23:0], b};
        m_bytes++;
        if (m_bytes % 4 == 0) m_commit(m_cur);
    endtask

    task automatic m_finish();
        int unsigned rem;
        rem = m_bytes % 4;
        if (rem != 0) m_commit(m_cur << (8 * (4 - rem)));
        m_run = 1'b1;
    endtask

    task automatic check_status(input string tag, input bit exp_run);
        int unsigned ewl;
        for (int k = 0; k < 2; k++) begin
            ewl = (m_words < depth[k]) ? m_words : depth[k];
            check($sformatf("%s_run[%0d]", tag, k),   32'(get_run(k)),   32'(exp_run));
            check($sformatf("%s_ready[%0d]", tag, k), 32'(get_ready(k)), 32'(!exp_run));
            check($sformatf("%s_wl[%0d]", tag, k),    get_wl(k),         ewl);
            check($sformatf("%s_err[%0d]", tag, k),   32'(get_err(k)),   32'(m_words > depth[k]));
        end
    endtask

    task automatic check_pc(input logic [31:0] p);
        int unsigned idx;
        pc = p;
        #1;
        for (int k = 0; k < 2; k++) begin
            if (!m_run) begin
                check($sformatf("inst_hold[%0d] pc=%h", k, p), get_inst(k), '0);
            end else if ((p >> (aw[k] + 2)) != 0) begin
                check($sformatf("inst_oor[%0d] pc=%h", k, p), get_inst(k), '0);
            end else begin
                idx = (p >> 2) & (depth[k] - 1);
                if (m_val[k][idx]) check($sformatf("inst[%0d] pc=%h", k, p), get_inst(k), m_mem[k][idx]);
            end
        end
    endtask

    task automatic check_reads();
        int unsigned last;
        last = (m_words < 255) ? m_words : 255;
        for (int unsigned i = 0; i <= last; i++) check_pc(i * 4 + $urandom_range(0, 3));
        check_pc(32'h0000_1000 | ($urandom & 32'h0000_0fff));
        check_pc($urandom);
        check_pc(32'h0000_0010);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last, input int gap);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk_cpu);
            ld_valid = 1'b0;
            ld_data  = 8'($urandom);
            ld_last  = 1'($urandom);
            reload   = 1'($urandom);
            check_pc(($urandom_range(0, 1) == 1) ? 32'h0 : $urandom);
            check_status("gap", 1'b0);
        end
        @(negedge clk_cpu);
        ld_valid = 1'b1;
        ld_data  = b;
        ld_last  = last;
        reload   = 1'($urandom);
        check_pc(($urandom_range(0, 1) == 1) ? 32'h0 : $urandom);
        check_status("ld", 1'b0);
        @(posedge clk_cpu);
        m_push(b);
    endtask

    task automatic finish_load();
        bit padded;
        padded = (m_bytes % 4) != 0;
        @(negedge clk_cpu);
        ld_valid = 1'($urandom);
        ld_data  = 8'($urandom);
        ld_last  = 1'b1;
        reload   = 1'b0;
        if (padded) begin
            ld_valid = 1'b1;
            reload   = 1'b1;
            check("pad_run", 32'(run_a), 32'h0);
            check("pad_ready", 32'(ready_a), 32'h0);
            check("pad_ready_b", 32'(ready_b), 32'h0);
            @(negedge clk_cpu);
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        reload   = 1'b0;
        m_finish();
        check_status("done", 1'b1);
    endtask

    task automatic load_image(input int max_gap, input bit toggle);
        for (int i = 0; i < img.size(); i++) begin
            send_byte(img[i], i == img.size() - 1, toggle ? 1 : $urandom_range(0, max_gap));
        end
        finish_load();
    endtask

    task automatic do_reload();
        @(negedge clk_cpu);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        reload   = 1'b1;
        @(posedge clk_cpu);
        m_restart();
        @(negedge clk_cpu);
        reload = 1'b0;
        check_status("reload", 1'b0);
    endtask

    task automatic random_image(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back(8'($urandom));
    endtask

    initial begin
        m_restart();
        #2 reset = 1'b0;
        #1;
        check_status("por", 1'b0);
        check_pc(32'h0);
        repeat (2) @(negedge clk_cpu);
        reset = 1'b1;

        // Aligned image, valid toggling every cycle
        img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hA0, 8'hB0, 8'hC0, 8'hD0};
        load_image(0, 1'b1);
        check("t1_wl", 32'(wl_a), 32'd2);
        check_pc(32'h0); check("t1_pc0", inst_a, 32'h01020304);
        check_pc(32'h4); check("t1_pc4", inst_a, 32'hA0B0C0D0);
        check_pc(32'h5); check("t1_pc5", inst_a, 32'hA0B0C0D0);
        check_reads();

        // Image ending mid-word goes through the pad cycle
        do_reload();
        img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        load_image(2, 1'b0);
        check("t2_wl", 32'(wl_a), 32'd2);
        check_pc(32'h4); check("t2_pc4", inst_a, 32'h55660000);
        check_reads();

        // 20 bytes: overflows the 4-word RAM only
        do_reload();
        img.delete();
        for (int i = 1; i <= 20; i++) img.push_back(8'(i));
        load_image(1, 1'b0);
        check("t3_wl_b", 32'(wl_b), 32'd4);
        check("t3_err_b", 32'(err_b), 32'd1);
        check("t3_wl_a", 32'(wl_a), 32'd5);
        check_pc(32'hC);  check("t3_pc12_b", inst_b, 32'h0D0E0F10);
        check_pc(32'h10); check("t3_pc16_b", inst_b, 32'h0);
        check("t3_pc16_a", inst_a, 32'h11121314);
        check_reads();

        // Reload clears overflow, old words beyond the new image persist
        do_reload();
        img = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        load_image(1, 1'b0);
        check("t4_err_b", 32'(err_b), 32'd0);
        check("t4_wl_b", 32'(wl_b), 32'd1);
        check_pc(32'h0); check("t4_pc0", inst_a, 32'hDEADBEEF);
        check_pc(32'h4); check("t4_pc4", inst_a, 32'h05060708);
        check_reads();

        // Loader bytes are ignored while running
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_cpu);
            ld_valid = 1'b1;
            ld_data  = 8'($urandom);
            ld_last  = 1'($urandom);
            check_status("run_ign", 1'b1);
        end
        @(negedge clk_cpu);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        check_status("run_ign", 1'b1);
        check_reads();

        // Exact fill and one padded word past the small RAM
        do_reload(); random_image(16); load_image(1, 1'b0); check_reads();
        do_reload(); random_image(17); load_image(1, 1'b0); check_reads();

        // Overflow of the large RAM
        do_reload(); random_image(1028); load_image(0, 1'b0);
        check("t7_wl_a", 32'(wl_a), 32'd256);
        check("t7_err_a", 32'(err_a), 32'd1);
        check_reads();

        // Random images
        for (int r = 0; r < 6; r++) begin
            do_reload();
            random_image($urandom_range(1, 24));
            load_image($urandom_range(0, 2), 1'b0);
            check_reads();
        end

        // Asynchronous reset after byte 2 of the second word
        do_reload();
        for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'b0, 0);
        @(negedge clk_cpu);
        ld_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        m_restart();
        check_status("rst_mid", 1'b0);
        check("rst_mid_inst", inst_a, 32'h0);
        @(negedge clk_cpu);
        reset = 1'b1;
        random_image(4);
        load_image(1, 1'b0);
        check_pc(32'h0);
        check("rst_fresh_pc0", inst_a, {img[0], img[1], img[2], img[3]});
        check_reads();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
